// File: rtl/pio_control_sequencer.sv
// Turns software-driven START/ABORT levels from the control PIO into one valid/ready command
// for the coprocessor. It then tracks completion, error or timeout as sticky status bits.
module pio_control_sequencer #(
    parameter int INSTR_W        = 32,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W          = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [1:0]         ctrl_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [INSTR_W-1:0] cmd_data,
    input  logic               op_done,
    input  logic               op_error,
    output logic               soft_rst,
    output logic [3:0]         status
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] TERM_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_COUNT  = '1;

    state_t           state;
    logic [1:0]       ctrl_r;
    logic [1:0]       ctrl_rr;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             error;
    logic             timeout;
    logic             start_evt;
    logic             start_ok;

    assign start_evt = ctrl_r[0] & ~ctrl_rr[0];
    // A START edge that coincides with ABORT falling is refused, so the staged ABORT bit counts too.
    assign start_ok  = start_evt & ~ctrl_r[1] & ~ctrl_rr[1];

    assign status = {timeout, error, done, busy};

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ctrl_r    <= '0;
            ctrl_rr   <= '0;
            count     <= '0;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            soft_rst  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            ctrl_r   <= ctrl_in;
            ctrl_rr  <= ctrl_r;
            soft_rst <= ctrl_r[1];

            if (ctrl_r[1]) begin
                state     <= S_IDLE;
                cmd_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b0;
                error     <= 1'b0;
                timeout   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_ok) begin
                            state     <= S_ISSUE;
                            cmd_valid <= 1'b1;
                            busy      <= 1'b1;
                            cmd_data  <= instr_in;
                            done      <= 1'b0;
                            error     <= 1'b0;
                            timeout   <= 1'b0;
                        end
                    end
                    S_ISSUE: begin
                        if (cmd_ready) begin
                            state     <= S_WAIT;
                            cmd_valid <= 1'b0;
                            count     <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (count != MAX_COUNT) begin
                            count <= count + CNT_W'(1);
                        end
                        // Error outranks done, and either outranks the timeout on the terminal cycle.
                        if (op_error) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else if (op_done) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else if (count == TERM_COUNT) begin
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        cmd_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pio_control_sequencer.sv
// Bench for pio_control_sequencer: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a command-level reference model.
module tb_pio_control_sequencer;

    localparam int INSTR_W = 32;
    localparam int T_CYC   = 16;
    localparam int CNT_W   = 5;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [1:0]         ctrl_in;
    logic [INSTR_W-1:0] instr_in;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [INSTR_W-1:0] cmd_data;
    logic               op_done;
    logic               op_error;
    logic               soft_rst;
    logic [3:0]         status;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_control_sequencer #(
        .INSTR_W(INSTR_W),
        .TIMEOUT_CYCLES(T_CYC),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ctrl_in(ctrl_in),
        .instr_in(instr_in),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data(cmd_data),
        .op_done(op_done),
        .op_error(op_error),
        .soft_rst(soft_rst),
        .status(status)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: where the single in-flight command is, and how long it has waited.
    typedef enum {M_IDLE, M_OFFERED, M_RUNNING} mphase_t;
    mphase_t            m_phase;
    logic [1:0]         m_c1, m_c2;
    logic               m_soft, m_done, m_err, m_to;
    logic [INSTR_W-1:0] m_data;
    int                 m_waited;
    bit                 m_start_ok;
    bit                 model_on = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = M_IDLE; m_c1 = '0; m_c2 = '0; m_soft = 0;
            m_done = 0; m_err = 0; m_to = 0; m_data = '0; m_waited = 0;
        end else begin
            m_start_ok = m_c1[0] && !m_c2[0] && !m_c1[1] && !m_c2[1];
            if (m_c1[1]) begin
                m_phase = M_IDLE; m_done = 0; m_err = 0; m_to = 0;
            end else begin
                case (m_phase)
                    M_IDLE: if (m_start_ok) begin
                        m_phase = M_OFFERED; m_data = instr_in;
                        m_done = 0; m_err = 0; m_to = 0;
                    end
                    M_OFFERED: if (cmd_ready) begin
                        m_phase = M_RUNNING; m_waited = 0;
                    end
                    M_RUNNING: begin
                        m_waited++;
                        if (op_error) begin m_err = 1; m_phase = M_IDLE; end
                        else if (op_done) begin m_done = 1; m_phase = M_IDLE; end
                        else if (m_waited == T_CYC) begin m_to = 1; m_phase = M_IDLE; end
                    end
                    default: m_phase = M_IDLE;
                endcase
            end
            m_soft = m_c1[1];
            m_c2   = m_c1;
            m_c1   = ctrl_in;
        end
    end

    always @(negedge clk) begin
        if (reset_n && model_on) begin
            check("cmd_valid", 32'(cmd_valid), 32'(m_phase == M_OFFERED));
            check("cmd_data", cmd_data, m_data);
            check("soft_rst", 32'(soft_rst), 32'(m_soft));
            check("status", 32'(status), 32'({m_to, m_err, m_done, m_phase != M_IDLE}));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic start_cmd(input logic [INSTR_W-1:0] word, input logic rdy);
        ctrl_in = 2'b00;
        tick(2);
        ctrl_in   = 2'b01;
        instr_in  = word;
        cmd_ready = rdy;
        tick(2);
    endtask

    initial begin
        reset_n = 1'b1; ctrl_in = 2'b00; instr_in = '0;
        cmd_ready = 1'b0; op_done = 1'b0; op_error = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
        check("reset_cmd_data", cmd_data, 32'd0);
        check("reset_status", 32'(status), 32'd0);
        check("reset_soft_rst", 32'(soft_rst), 32'd0);
        tick(2);
        reset_n  = 1'b1;
        model_on = 1'b1;
        tick(2);

        // Single command, immediate accept, done pulse
        start_cmd(32'hA5A5_0001, 1'b1);
        check("t1_valid_high", 32'(cmd_valid), 32'd1);
        check("t1_data", cmd_data, 32'hA5A5_0001);
        check("t1_busy", 32'(status), 32'b0001);
        tick();
        check("t1_valid_one_cycle", 32'(cmd_valid), 32'd0);
        tick(4);
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        check("t1_done_status", 32'(status), 32'b0010);

        // Back-pressure: command must hold while instr_in moves
        start_cmd(32'h1234_5678, 1'b0);
        for (int i = 0; i < 10; i++) begin
            instr_in = $urandom;
            tick();
            check("t2_valid_held", 32'(cmd_valid), 32'd1);
            check("t2_data_held", cmd_data, 32'h1234_5678);
        end
        cmd_ready = 1'b1;
        tick();
        check("t2_accepted", 32'(cmd_valid), 32'd0);
        check("t2_wait_busy", 32'(status), 32'b0001);
        op_done = 1'b1;
        tick();
        op_done = 1'b0;

        // Timeout after T_CYC WAIT cycles
        start_cmd(32'h0000_00A3, 1'b1);
        tick();
        tick(T_CYC - 1);
        check("t3_not_yet", 32'(status), 32'b0001);
        tick();
        check("t3_timeout", 32'(status), 32'b1000);
        ctrl_in = 2'b00;
        tick(2);
        check("t3_sticky", 32'(status), 32'b1000);
        ctrl_in = 2'b01;
        tick(2);
        check("t3_restart_busy", 32'(status), 32'b0001);
        tick();

        // Extra START while busy, then done+error together
        ctrl_in = 2'b00;
        tick(2);
        ctrl_in = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_no_extra_valid", 32'(cmd_valid), 32'd0);
        end
        op_done = 1'b1; op_error = 1'b1;
        tick();
        op_done = 1'b0; op_error = 1'b0;
        check("t4_error_wins", 32'(status), 32'b0100);

        // ABORT during WAIT
        start_cmd(32'hCAFE_0005, 1'b1);
        tick();
        ctrl_in = 2'b11;
        tick(2);
        check("t5_soft_rst", 32'(soft_rst), 32'd1);
        check("t5_status_clear", 32'(status), 32'd0);
        ctrl_in = 2'b10;
        tick();
        ctrl_in = 2'b11;
        tick(2);
        check("t5_start_blocked", 32'(cmd_valid), 32'd0);
        ctrl_in = 2'b10;
        tick(2);
        ctrl_in = 2'b01;
        tick(3);
        check("t5_fall_start_ignored", 32'(cmd_valid), 32'd0);
        check("t5_idle_status", 32'(status), 32'd0);
        check("t5_soft_rst_off", 32'(soft_rst), 32'd0);

        // Async reset mid-ISSUE
        start_cmd(32'hBEEF_0006, 1'b0);
        check("t6_issue", 32'(cmd_valid), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(cmd_valid), 32'd0);
        check("t6_async_status", 32'(status), 32'd0);
        check("t6_async_soft", 32'(soft_rst), 32'd0);
        ctrl_in = 2'b00;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        check("t6_idle_after", 32'(cmd_valid), 32'd0);
        check("t6_status_after", 32'(status), 32'd0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0)  ctrl_in[0] = ~ctrl_in[0];
            if ($urandom_range(39) == 0) ctrl_in[1] = ~ctrl_in[1];
            cmd_ready = ($urandom_range(2) != 0);
            op_done   = ($urandom_range(24) == 0);
            op_error  = ($urandom_range(59) == 0);
            instr_in  = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
